// File: rtl/dmem_arbiter_pkg.sv
// Shared constants, state encodings and request payload type for the data-memory arbiter.
package dmem_pkg;

  localparam int unsigned DMEM_BYTES_DEFAULT = 1024;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned SEL_W  = 8;

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam logic [0:0] ARB_S  = 1'b0;
  localparam logic [0:0] LOCK_S = 1'b1;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [SEL_W-1:0]  sel;
  } dmem_req_t;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr, input int unsigned bytes);
    return addr < ADDR_W'(bytes);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Per-port request/response channel between a requester (LSU or debug) and the arbiter.
interface dmem_arbiter_if;
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [SEL_W-1:0]  req_sel;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_sel,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_sel,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin picker; lock forces D-only service, force_d marks D as last winner.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_c,
  input  logic req_d,
  input  logic lock,
  input  logic force_d,
  output logic gnt_c,
  output logic gnt_d
);

  logic last_grant;

  always_comb begin
    gnt_c = 1'b0;
    gnt_d = 1'b0;
    if (lock) begin
      gnt_d = req_d;
    end else if (req_c && req_d) begin
      gnt_c = (last_grant == PORT_D);
      gnt_d = (last_grant == PORT_C);
    end else begin
      gnt_c = req_c;
      gnt_d = req_d;
    end
  end

  // History only moves on an accepted request, or on lock release.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= PORT_D;
    end else if (force_d || gnt_d) begin
      last_grant <= PORT_D;
    end else if (gnt_c) begin
      last_grant <= PORT_C;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported dmem between core (C) and debug/DMA (D) with round-robin and debug lock.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned DMEM_BYTES = DMEM_BYTES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  dmem_arbiter_if.slave     c,
  dmem_arbiter_if.slave     d,
  input  logic              d_lock,
  output logic              d_locked,
  output logic              we_dmem,
  output logic [SEL_W-1:0]  dmem_word_sel,
  output logic [ADDR_W-1:0] r_dmem_addr,
  output logic [DATA_W-1:0] w_dmem_data,
  input  logic [DATA_W-1:0] dmem_data
);

  logic [0:0]  state;
  logic [0:0]  state_nxt;
  logic        locked;
  logic        exit_lock;
  logic        gnt_c;
  logic        gnt_d;
  logic        granted;
  logic        in_rng;
  dmem_req_t   req_c;
  dmem_req_t   req_d;
  dmem_req_t   req;

  logic              c_rsp_valid_q, d_rsp_valid_q;
  logic              c_rsp_err_q,   d_rsp_err_q;
  logic [DATA_W-1:0] c_rsp_data_q,  d_rsp_data_q;

  assign locked    = (state == LOCK_S);
  assign exit_lock = locked & ~d_lock;
  assign d_locked  = locked;

  // Requests are masked during reset so nothing reaches the memory.
  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_c   (c.req_valid & ~rst),
    .req_d   (d.req_valid & ~rst),
    .lock    (locked),
    .force_d (exit_lock),
    .gnt_c   (gnt_c),
    .gnt_d   (gnt_d)
  );

  assign c.req_ready = gnt_c;
  assign d.req_ready = gnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_S;
    end else begin
      state <= state_nxt;
    end
  end

  // Lock is only taken on a cycle in which C is not being accepted.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_S:   if (d_lock && !gnt_c) state_nxt = LOCK_S;
      LOCK_S:  if (!d_lock) state_nxt = ARB_S;
      default: state_nxt = ARB_S;
    endcase
  end

  assign req_c   = '{we: c.req_we, addr: c.req_addr, wdata: c.req_wdata, sel: c.req_sel};
  assign req_d   = '{we: d.req_we, addr: d.req_addr, wdata: d.req_wdata, sel: d.req_sel};
  assign req     = gnt_d ? req_d : req_c;
  assign granted = gnt_c | gnt_d;
  assign in_rng  = addr_in_range(req.addr, DMEM_BYTES);

  always_comb begin
    we_dmem       = 1'b0;
    dmem_word_sel = '0;
    r_dmem_addr   = '0;
    w_dmem_data   = '0;
    if (granted) begin
      r_dmem_addr   = req.addr;
      w_dmem_data   = req.wdata;
      dmem_word_sel = req.we ? req.sel : '0;
      we_dmem       = req.we & in_rng;
    end
  end

  // Load data is captured at the same edge that commits a store.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_rsp_valid_q <= 1'b0;
      c_rsp_err_q   <= 1'b0;
      c_rsp_data_q  <= '0;
      d_rsp_valid_q <= 1'b0;
      d_rsp_err_q   <= 1'b0;
      d_rsp_data_q  <= '0;
    end else begin
      c_rsp_valid_q <= gnt_c;
      c_rsp_err_q   <= gnt_c & ~in_rng;
      c_rsp_data_q  <= (gnt_c && !req.we && in_rng) ? dmem_data : '0;
      d_rsp_valid_q <= gnt_d;
      d_rsp_err_q   <= gnt_d & ~in_rng;
      d_rsp_data_q  <= (gnt_d && !req.we && in_rng) ? dmem_data : '0;
    end
  end

  assign c.rsp_valid = c_rsp_valid_q;
  assign c.rsp_err   = c_rsp_err_q;
  assign c.rsp_data  = c_rsp_data_q;
  assign d.rsp_valid = d_rsp_valid_q;
  assign d.rsp_err   = d_rsp_err_q;
  assign d.rsp_data  = d_rsp_data_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: drivers push expected responses, a negedge monitor pops and compares.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int MAXW = 40;

  typedef struct {
    logic [63:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_lock;
  logic        d_locked;
  logic        we_dmem;
  logic [7:0]  dmem_word_sel;
  logic [63:0] r_dmem_addr;
  logic [63:0] w_dmem_data;
  logic [63:0] dmem_data;

  dmem_arbiter_if c_if ();
  dmem_arbiter_if d_if ();

  always #5 clk = ~clk;

  dmem_arbiter #(.DMEM_BYTES(1024)) dut (
    .clk           (clk),
    .rst           (rst),
    .c             (c_if.slave),
    .d             (d_if.slave),
    .d_lock        (d_lock),
    .d_locked      (d_locked),
    .we_dmem       (we_dmem),
    .dmem_word_sel (dmem_word_sel),
    .r_dmem_addr   (r_dmem_addr),
    .w_dmem_data   (w_dmem_data),
    .dmem_data     (dmem_data)
  );

  // Memory model: combinational read, byte-lane write at the rising edge.
  logic [63:0] mem      [128];
  logic [63:0] init_mem [128];
  logic [63:0] snap     [128];
  logic        do_init;

  assign dmem_data = mem[r_dmem_addr[9:3]];

  always @(posedge clk) begin
    if (do_init) begin
      for (int i = 0; i < 128; i++) mem[i] <= init_mem[i];
    end else if (we_dmem) begin
      for (int b = 0; b < 8; b++)
        if (dmem_word_sel[b]) mem[r_dmem_addr[9:3]][b*8 +: 8] <= w_dmem_data[b*8 +: 8];
    end
  end

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t cq[$];
  exp_t dq[$];
  bit   grant_log[$];
  logic       g_we   [2];
  logic [7:0] g_sel  [2];
  logic [63:0] g_addr[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic set_req(input bit p, input logic v, input logic we, input logic [63:0] a,
                         input logic [63:0] wd, input logic [7:0] s);
    if (p) begin
      d_if.req_valid = v; d_if.req_we = we; d_if.req_addr = a; d_if.req_wdata = wd; d_if.req_sel = s;
    end else begin
      c_if.req_valid = v; c_if.req_we = we; c_if.req_addr = a; c_if.req_wdata = wd; c_if.req_sel = s;
    end
  endtask

  // Called just after a rising edge; returns just after the edge that ends the grant cycle.
  task automatic drive(input bit p, input logic we, input logic [63:0] a, input logic [63:0] wd,
                       input logic [7:0] s, input logic [63:0] exp_data, input logic exp_err,
                       output int waits);
    bit got;
    got   = 1'b0;
    waits = 0;
    set_req(p, 1'b1, we, a, wd, s);
    while (!got && waits < MAXW) begin
      @(negedge clk);
      if (p ? d_if.req_ready : c_if.req_ready) begin
        got = 1'b1;
        if (p) dq.push_back('{exp_data, exp_err});
        else   cq.push_back('{exp_data, exp_err});
        grant_log.push_back(p);
        g_we[p]   = we_dmem;
        g_sel[p]  = dmem_word_sel;
        g_addr[p] = r_dmem_addr;
      end else begin
        waits++;
      end
      @(posedge clk); #1;
    end
    if (!got) chk(p ? "d_grant_timeout" : "c_grant_timeout", 64'(got), 64'd1);
    set_req(p, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Monitor: every response pulse must match the oldest expectation for its port.
  always @(negedge clk) begin
    exp_t e;
    if (c_if.rsp_valid) begin
      if (cq.size() == 0) chk("c_rsp_spurious", 64'(c_if.rsp_valid), 64'd0);
      else begin
        e = cq.pop_front();
        chk("c_rsp_data", c_if.rsp_data, e.data);
        chk("c_rsp_err", 64'(c_if.rsp_err), 64'(e.err));
      end
    end
    if (d_if.rsp_valid) begin
      if (dq.size() == 0) chk("d_rsp_spurious", 64'(d_if.rsp_valid), 64'd0);
      else begin
        e = dq.pop_front();
        chk("d_rsp_data", d_if.rsp_data, e.data);
        chk("d_rsp_err", 64'(d_if.rsp_err), 64'(e.err));
      end
    end
    if (c_if.rsp_valid && d_if.rsp_valid) chk("rsp_both_high", 64'd1, 64'd0);
    if (c_if.req_ready && d_if.req_ready) chk("ready_both_high", 64'd1, 64'd0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w, w2, diffs;
    for (int i = 0; i < 128; i++) init_mem[i] = 64'h0;
    init_mem[0]  = 64'hA5A5A5A5A5A5A5A5;
    init_mem[1]  = 64'h0101010101010101;
    init_mem[3]  = 64'h3333333333333333;
    init_mem[5]  = 64'h1122334455667788;
    init_mem[6]  = 64'h6666666666666666;
    init_mem[7]  = 64'h7777777777777777;
    init_mem[8]  = 64'h8888888888888888;
    init_mem[9]  = 64'h9999999999999999;

    rst = 1'b1; d_lock = 1'b0; do_init = 1'b1;
    set_req(PORT_C, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00);
    set_req(PORT_D, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00);
    @(posedge clk); #1 do_init = 1'b0;
    @(negedge clk);
    chk("rst_c_rsp_valid", 64'(c_if.rsp_valid), 64'd0);
    chk("rst_d_rsp_valid", 64'(d_if.rsp_valid), 64'd0);
    chk("rst_c_rsp_err",   64'(c_if.rsp_err), 64'd0);
    chk("rst_c_rsp_data",  c_if.rsp_data, 64'h0);
    chk("rst_d_locked",    64'(d_locked), 64'd0);
    chk("rst_we_dmem",     64'(we_dmem), 64'd0);
    chk("rst_word_sel",    64'(dmem_word_sel), 64'd0);
    chk("rst_addr",        r_dmem_addr, 64'h0);
    chk("rst_wdata",       w_dmem_data, 64'h0);
    @(posedge clk); #1 rst = 1'b0;

    // Core-only load
    drive(PORT_C, 1'b0, 64'h28, 64'h0, 8'h00, 64'h1122334455667788, 1'b0, w);
    chk("c_load_latency", 64'(w), 64'd0);
    chk("c_load_addr", g_addr[PORT_C], 64'h28);
    chk("c_load_we", 64'(g_we[PORT_C]), 64'd0);
    chk("c_load_sel", 64'(g_sel[PORT_C]), 64'd0);
    @(posedge clk); #1;

    // Contention from reset: C, D, C, D
    do_reset();
    grant_log.delete();
    fork
      begin
        drive(PORT_C, 1'b0, 64'h30, 64'h0, 8'h00, 64'h6666666666666666, 1'b0, w);
        drive(PORT_C, 1'b0, 64'h38, 64'h0, 8'h00, 64'h7777777777777777, 1'b0, w);
      end
      begin
        drive(PORT_D, 1'b0, 64'h40, 64'h0, 8'h00, 64'h8888888888888888, 1'b0, w2);
        drive(PORT_D, 1'b0, 64'h48, 64'h0, 8'h00, 64'h9999999999999999, 1'b0, w2);
      end
    join
    chk("rr_log_size", 64'(grant_log.size()), 64'd4);
    if (grant_log.size() == 4) begin
      chk("rr_grant0", 64'(grant_log[0]), 64'(PORT_C));
      chk("rr_grant1", 64'(grant_log[1]), 64'(PORT_D));
      chk("rr_grant2", 64'(grant_log[2]), 64'(PORT_C));
      chk("rr_grant3", 64'(grant_log[3]), 64'(PORT_D));
    end
    @(posedge clk); #1;

    // Byte-lane store then back-to-back load; sel=0 store is a no-op
    drive(PORT_D, 1'b1, 64'h10, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 64'h0, 1'b0, w);
    chk("d_store_we", 64'(g_we[PORT_D]), 64'd1);
    chk("d_store_sel", 64'(g_sel[PORT_D]), 64'h0F);
    drive(PORT_D, 1'b0, 64'h10, 64'h0, 8'h00, 64'h00000000FFFFFFFF, 1'b0, w);
    drive(PORT_C, 1'b1, 64'h18, 64'hDEADBEEFDEADBEEF, 8'h00, 64'h0, 1'b0, w);
    drive(PORT_C, 1'b0, 64'h18, 64'h0, 8'h00, 64'h3333333333333333, 1'b0, w);
    @(posedge clk); #1;

    // Out-of-range store and load
    for (int i = 0; i < 128; i++) snap[i] = mem[i];
    drive(PORT_C, 1'b1, 64'h400, 64'hDEADDEADDEADDEAD, 8'hFF, 64'h0, 1'b1, w);
    chk("oor_store_we", 64'(g_we[PORT_C]), 64'd0);
    drive(PORT_C, 1'b0, 64'h408, 64'h0, 8'h00, 64'h0, 1'b1, w);
    repeat (2) @(posedge clk); #1;
    diffs = 0;
    for (int i = 0; i < 128; i++) if (mem[i] !== snap[i]) diffs++;
    chk("oor_mem_unchanged", 64'(diffs), 64'd0);

    // Lock while C streams loads; D stores during the lock
    fork
      begin
        drive(PORT_C, 1'b0, 64'h28, 64'h0, 8'h00, 64'h1122334455667788, 1'b0, w);
        drive(PORT_C, 1'b0, 64'h30, 64'h0, 8'h00, 64'h6666666666666666, 1'b0, w2);
      end
      begin
        d_lock = 1'b1;
        @(negedge clk);
        chk("lock_inflight_c_ready", 64'(c_if.req_ready), 64'd1);
        for (int i = 1; i <= 10; i++) begin
          @(posedge clk); #1;
          @(negedge clk);
          chk("lock_c_ready_low", 64'(c_if.req_ready), 64'd0);
          if (i >= 2) chk("lock_d_locked", 64'(d_locked), 64'd1);
        end
        @(posedge clk); #1 d_lock = 1'b0;
        @(negedge clk);
        chk("release_cycle_c_ready", 64'(c_if.req_ready), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("after_release_c_ready", 64'(c_if.req_ready), 64'd1);
        chk("after_release_unlocked", 64'(d_locked), 64'd0);
      end
      begin
        int wd;
        @(posedge clk); #1;
        drive(PORT_D, 1'b1, 64'h50, 64'hAAAAAAAAAAAAAAAA, 8'hFF, 64'h0, 1'b0, wd);
        drive(PORT_D, 1'b1, 64'h58, 64'hBBBBBBBBBBBBBBBB, 8'hFF, 64'h0, 1'b0, wd);
        drive(PORT_D, 1'b1, 64'h60, 64'hCCCCCCCCCCCCCCCC, 8'hF0, 64'h0, 1'b0, wd);
      end
    join
    chk("lock_c_wait_cycles", 64'(w2), 64'd11);
    drive(PORT_D, 1'b0, 64'h50, 64'h0, 8'h00, 64'hAAAAAAAAAAAAAAAA, 1'b0, w);
    drive(PORT_D, 1'b0, 64'h60, 64'h0, 8'h00, 64'hCCCCCCCC00000000, 1'b0, w);
    @(posedge clk); #1;

    // Reset while locked, with a D request pending
    d_lock = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("relock_d_locked", 64'(d_locked), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    set_req(PORT_D, 1'b1, 1'b0, 64'h28, 64'h0, 8'h00);
    @(negedge clk);
    chk("rst_blocks_d_ready", 64'(d_if.req_ready), 64'd0);
    chk("rst_blocks_we", 64'(we_dmem), 64'd0);
    @(posedge clk); #1;
    set_req(PORT_D, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00);
    d_lock = 1'b0;
    @(negedge clk);
    chk("rst_lock_cleared", 64'(d_locked), 64'd0);
    chk("rst_no_d_rsp", 64'(d_if.rsp_valid), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // After reset, C wins the first tie
    grant_log.delete();
    fork
      drive(PORT_C, 1'b0, 64'h28, 64'h0, 8'h00, 64'h1122334455667788, 1'b0, w);
      drive(PORT_D, 1'b0, 64'h40, 64'h0, 8'h00, 64'h8888888888888888, 1'b0, w2);
    join
    chk("post_rst_first_grant", 64'(grant_log.size() > 0 ? grant_log[0] : 1'b1), 64'(PORT_C));

    repeat (3) @(posedge clk);
    #1;
    chk("c_queue_drained", 64'(cq.size()), 64'd0);
    chk("d_queue_drained", 64'(dq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
